mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port of the multi-cycle RISC-V core between the fetch unit and the load/store unit. It holds at most one outstanding memory transaction, times the fixed-latency memory response with an internal counter, routes read data back to the owning requester, and stops fetch from being starved by back-to-back data accesses. It sits between `Processor_Top`'s fetch/LSU logic and the memory model.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and LSU, one transaction in flight.
// Grant is combinational in IDLE (0 cycles); rvalid follows MEM_LAT cycles later; requests held while BUSY.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_TWO    = CW'(2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic        pick_ls, pick_if;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    pick_ls     = 1'b0;
    pick_if     = 1'b0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;

    unique case (state_q)
      IDLE: begin
        // Gating on rst keeps the combinational grant quiet while reset is held.
        if (rst) begin
          pick_ls = ls_req && !(if_req && (starve_q == STARVE_LIM));
          pick_if = if_req && !pick_ls;
        end
        if (pick_ls) begin
          ls_gnt    = 1'b1;
          mem_req   = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          mem_be    = ls_be;
          owner_d   = OWN_LS;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (pick_if) begin
          if_gnt   = 1'b1;
          mem_req  = 1'b1;
          mem_addr = if_addr;
          mem_be   = '1;
          owner_d  = OWN_IF;
          starve_d = '0;
        end
        if (pick_ls || pick_if) begin
          state_d = BUSY;
          cnt_d   = LAT_LOAD;
          if (MEM_LAT == 1) begin
            if_rvalid_d = pick_if;
            ls_rvalid_d = pick_ls;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
        // Arm rvalid one cycle early so the flop lands in the cycle memory data is valid.
        if ((MEM_LAT > 1) && (cnt_q == CNT_TWO)) begin
          if_rvalid_d = (owner_q == OWN_IF);
          ls_rvalid_d = (owner_q == OWN_LS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if (if_rvalid_q) begin
        if_rdata_q <= mem_rdata;
      end
      if (ls_rvalid_q) begin
        ls_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory data is only valid in the rvalid cycle; forward it then and hold the captured copy after.
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rvalid_q ? mem_rdata : if_rdata_q;
  assign ls_rdata  = ls_rvalid_q ? mem_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, cycle monitor with response scoreboard, scenario tasks.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_ls;
    bit          is_st;
    logic [31:0] dat;
    int          due;
  } sb_t;
  typedef struct {
    logic [31:0] dat;
    int          due;
  } pend_t;
  typedef struct {
    bit is_ls;
    int at;
  } gnt_t;

  sb_t   sb[$];
  pend_t pend[$];
  gnt_t  glog[$];
  logic [31:0] mem_arr [logic [31:0]];

  int          m_idle_cyc = 0;
  int          m_starve = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;
  bit          e_ls, e_if, e_ifv, e_lsv, idle_now;
  logic [31:0] e_addr, e_wdata, rd;
  logic [3:0]  e_be;
  bit          e_we;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory drives its response during exactly the cycle MEM_LAT after the request.
  always @(posedge clk) begin
    #1;
    mem_rdata = 32'hBAD0_BAD0;
    while (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      if (pend[0].due == cyc + 1) mem_rdata = pend[0].dat;
      void'(pend.pop_front());
    end
  end

  // Mid-cycle monitor: reference arbitration, memory command and response scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      checks++;
      if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we,
           mem_addr, mem_wdata, mem_be} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d gnt=%b/%b rv=%b/%b mem_req=%b rdata=%h/%h required all zero",
                 cyc, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, if_rdata, ls_rdata);
      end
      sb.delete();
      m_idle_cyc = 0;
      m_starve = 0;
      last_if = '0;
      last_ls = '0;
    end else begin
      idle_now = (cyc >= m_idle_cyc);
      e_ls = idle_now && ls_req && !(if_req && (m_starve == STARVE_MAX));
      e_if = idle_now && if_req && !e_ls;
      checks++;
      if ({if_gnt, ls_gnt, mem_req} !== {e_if, e_ls, e_if | e_ls}) begin
        errors++;
        $display("FAIL grant cyc=%0d if_gnt/ls_gnt/mem_req=%b%b%b required %b%b%b",
                 cyc, if_gnt, ls_gnt, mem_req, e_if, e_ls, e_if | e_ls);
      end
      if (e_ls || e_if) begin
        e_addr  = e_ls ? ls_addr : if_addr;
        e_we    = e_ls && ls_we;
        e_wdata = e_ls ? ls_wdata : 32'h0;
        e_be    = e_ls ? ls_be : 4'hF;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !== {e_we, e_addr, e_wdata, e_be}) begin
          errors++;
          $display("FAIL mem_cmd cyc=%0d we=%b addr=%h wdata=%h be=%b required we=%b addr=%h wdata=%h be=%b",
                   cyc, mem_we, mem_addr, mem_wdata, mem_be, e_we, e_addr, e_wdata, e_be);
        end
        rd = mem_read(e_addr);
        if (e_we) begin
          for (int b = 0; b < 4; b++) if (e_be[b]) rd[b*8 +: 8] = e_wdata[b*8 +: 8];
          mem_arr[e_addr] = rd;
          rd = 32'h5707_E000 ^ e_addr;
        end
        sb.push_back('{is_ls: e_ls, is_st: e_we, dat: rd, due: cyc + MEM_LAT});
        pend.push_back('{dat: rd, due: cyc + MEM_LAT});
        glog.push_back('{is_ls: e_ls, at: cyc});
        m_idle_cyc = cyc + MEM_LAT + 1;
        if (e_if || !if_req) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
      end
      while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
      e_ifv = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].is_ls;
      e_lsv = (sb.size() > 0) && (sb[0].due == cyc) && sb[0].is_ls;
      checks++;
      if ({if_rvalid, ls_rvalid} !== {e_ifv, e_lsv}) begin
        errors++;
        $display("FAIL rvalid cyc=%0d if_rvalid/ls_rvalid=%b%b required %b%b",
                 cyc, if_rvalid, ls_rvalid, e_ifv, e_lsv);
      end
      if (e_ifv) begin
        last_if = sb[0].dat;
        checks++;
        if (if_rdata !== sb[0].dat) begin
          errors++;
          $display("FAIL if_rdata cyc=%0d got %h required %h", cyc, if_rdata, sb[0].dat);
        end
        void'(sb.pop_front());
      end else begin
        checks++;
        if (if_rdata !== last_if) begin
          errors++;
          $display("FAIL if_rdata_hold cyc=%0d got %h required %h", cyc, if_rdata, last_if);
        end
      end
      if (e_lsv) begin
        last_ls = sb[0].dat;
        if (!sb[0].is_st) begin
          checks++;
          if (ls_rdata !== sb[0].dat) begin
            errors++;
            $display("FAIL ls_rdata cyc=%0d got %h required %h", cyc, ls_rdata, sb[0].dat);
          end
        end
        void'(sb.pop_front());
      end else begin
        checks++;
        if (ls_rdata !== last_ls) begin
          errors++;
          $display("FAIL ls_rdata_hold cyc=%0d got %h required %h", cyc, ls_rdata, last_ls);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  task automatic wait_rv(input bit want_ls, output int lat, output logic [31:0] dat,
                         output bit other);
    lat = -1;
    dat = '0;
    other = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (want_ls ? if_rvalid : ls_rvalid) other = 1'b1;
      if (want_ls ? ls_rvalid : if_rvalid) begin
        lat = n;
        dat = want_ls ? ls_rdata : if_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] d;
    bit other;
    #1 rst = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold gnt=%b%b mem_req=%b rv=%b%b required 0", if_gnt, ls_gnt,
                 mem_req, if_rvalid, ls_rvalid);
      end
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_req, mem_addr} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_fetch_grant if_gnt=%b mem_req=%b mem_addr=%h required 1 1 00000000",
               if_gnt, mem_req, mem_addr);
    end
    tick();
    drop_all();
    wait_rv(1'b0, lat, d, other);
    checks++;
    if (lat != MEM_LAT || d !== 32'h0000_0093) begin
      errors++;
      $display("FAIL first_fetch_resp latency=%0d data=%h required %0d 00000093", lat, d, MEM_LAT);
    end
  endtask

  task automatic test_store();
    int lat;
    logic [31:0] d;
    bit other;
    repeat (3) tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b1111;
    @(negedge clk);
    checks++;
    if ({ls_gnt, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL store_cmd gnt=%b we=%b addr=%h wdata=%h be=%b required 1 1 00000100 deadbeef 1111",
               ls_gnt, mem_we, mem_addr, mem_wdata, mem_be);
    end
    tick();
    drop_all();
    wait_rv(1'b1, lat, d, other);
    checks++;
    if (lat != MEM_LAT || other) begin
      errors++;
      $display("FAIL store_resp latency=%0d if_rvalid_seen=%0b required %0d 0", lat, other, MEM_LAT);
    end
  endtask

  task automatic test_load();
    int lat;
    logic [31:0] d;
    bit other;
    repeat (3) tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_be = 4'hF;
    @(negedge clk);
    checks++;
    if ({ls_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      errors++;
      $display("FAIL load_cmd gnt=%b we=%b addr=%h required 1 0 00000200", ls_gnt, mem_we, mem_addr);
    end
    tick();
    drop_all();
    wait_rv(1'b1, lat, d, other);
    checks++;
    if (lat != MEM_LAT || d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_resp latency=%0d data=%h required %0d 12345678", lat, d, MEM_LAT);
    end
  endtask

  task automatic run_both(input int n);
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'hF;
    repeat (n) tick();
  endtask

  task automatic check_order(input string tag);
    bit exp_ls [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (glog.size() < 5) begin
      errors++;
      $display("FAIL %s_count grants=%0d required at least 5", tag, glog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (glog[i].is_ls != exp_ls[i]) begin
          errors++;
          $display("FAIL %s_owner grant %0d is_ls=%0b required %0b", tag, i, glog[i].is_ls, exp_ls[i]);
        end
        if (i > 0) begin
          checks++;
          if (glog[i].at - glog[i-1].at != MEM_LAT + 1) begin
            errors++;
            $display("FAIL %s_spacing grant %0d gap=%0d required %0d", tag, i,
                     glog[i].at - glog[i-1].at, MEM_LAT + 1);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) tick();
    glog.delete();
    run_both(16);
    drop_all();
    check_order("b2b");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bit got2 = 1'b0;
    repeat (3) tick();
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_fetch_grant if_gnt=%b required 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (if_rvalid) seen++;
    end
    tick();
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (if_rvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_rvalid if_rvalid pulses=%0d required 0", seen);
    end
    // Build up starvation, abort an LS access, and confirm the count restarted from zero.
    tick();
    glog.delete();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'hF;
    for (int n = 0; n < 20 && !got2; n++) begin
      tick();
      got2 = (glog.size() >= 2);
    end
    checks++;
    if (!got2) begin
      errors++;
      $display("FAIL abort_setup grants=%0d required 2", glog.size());
    end
    rst = 1'b0;
    repeat (2) tick();
    glog.delete();
    rst = 1'b1;
    repeat (16) tick();
    drop_all();
    check_order("post_reset");
  endtask

  task automatic test_if_pulse_busy();
    int gnts = 0;
    int reqs = 0;
    int lat;
    logic [31:0] d;
    bit other;
    repeat (4) tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_be = 4'hF;
    @(negedge clk);
    checks++;
    if (ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL pulse_ls_grant ls_gnt=%b required 1", ls_gnt);
    end
    tick();
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    if (if_gnt) gnts++;
    if (mem_req) reqs++;
    tick();
    if_req = 1'b0;
    wait_rv(1'b1, lat, d, other);
    checks++;
    if (lat != MEM_LAT - 1 || d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL pulse_ls_resp latency=%0d data=%h required %0d deadbeef", lat, d, MEM_LAT - 1);
    end
    repeat (5) begin
      @(negedge clk);
      if (if_gnt) gnts++;
      if (mem_req) reqs++;
    end
    checks++;
    if (gnts != 0 || reqs != 0) begin
      errors++;
      $display("FAIL pulse_no_grant if_gnt=%0d mem_req=%0d required 0 0", gnts, reqs);
    end
  endtask

  initial begin
    mem_arr[32'h0]   = 32'h0000_0093;
    mem_arr[32'h200] = 32'h1234_5678;
    test_reset();
    test_store();
    test_back_to_back();
    test_load();
    test_reset_mid();
    test_if_pulse_busy();
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
